// File: rtl/adc_pkg.sv
// Shared constants, FSM state and sample payload for the ADC frame reader.
package adc_pkg;

    localparam int unsigned NUM_CH   = 8;
    localparam int unsigned SAMPLE_W = 10;
    localparam int unsigned CH_W     = $clog2(NUM_CH);
    localparam int unsigned FRAME_W  = NUM_CH * SAMPLE_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] data;
        logic [CH_W-1:0]     chan;
        logic                last;
    } sample_t;

    // Bit offset of channel ch inside a packed frame word.
    function automatic int unsigned slice_lo(input logic [CH_W-1:0] ch);
        return 32'(ch) * SAMPLE_W;
    endfunction

endpackage

// File: rtl/adc_frame_reader_if.sv
// Per-channel sample stream with valid/ready handshake.
interface adc_frame_reader_if;
    import adc_pkg::*;

    logic                m_valid;
    logic                m_ready;
    logic [SAMPLE_W-1:0] m_data;
    logic [CH_W-1:0]     m_chan;
    logic                m_last;

    modport master (output m_valid, m_data, m_chan, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_chan, m_last, output m_ready);

endinterface

// File: rtl/adc_next_chan.sv
// Finds the lowest enabled channel strictly above idx (or the lowest overall
// when from_start is set); none flags that no such channel exists.
module adc_next_chan
    import adc_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   idx,
    input  logic              from_start,
    output logic [CH_W-1:0]   nxt,
    output logic              none
);

    // Scan downward so the last hit is the lowest qualifying channel.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(idx)))) begin
                nxt  = CH_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adc_frame_reader.sv
// Snapshots a packed multi-channel ADC frame and drains the enabled channels
// as a valid/ready sample stream, counting frames that arrive while busy.
module adc_frame_reader
    import adc_pkg::*;
#(
    parameter int unsigned DROP_W = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic [NUM_CH-1:0]  ch_mask,
    adc_frame_reader_if.master stream,
    output logic               busy,
    output logic [DROP_W-1:0]  drop_count
);

    state_t              state, state_d;
    logic [FRAME_W-1:0]  snap_data, snap_data_d;
    logic [NUM_CH-1:0]   snap_mask, snap_mask_d;
    sample_t             out_q, out_d;
    logic                valid_q, valid_d;
    logic                busy_d;
    logic [DROP_W-1:0]   drop_d;

    logic                hs, capture, advance, drop;
    logic [NUM_CH-1:0]   scan_mask;
    logic [CH_W-1:0]     scan_ch, tail_ch;
    logic                scan_none, tail_none;
    logic                unused_scan;

    // out_q.chan doubles as the drain pointer.
    assign hs      = valid_q && stream.m_ready;
    assign capture = frame_valid && (|ch_mask) && ((state == IDLE) || (hs && out_q.last));
    assign advance = (state == SEND) && hs && !out_q.last;
    assign drop    = (state == SEND) && frame_valid && !(hs && out_q.last);

    assign scan_mask = capture ? ch_mask : snap_mask;

    adc_next_chan u_scan (
        .mask       (scan_mask),
        .idx        (out_q.chan),
        .from_start (capture),
        .nxt        (scan_ch),
        .none       (scan_none)
    );

    // Looks one step past the newly selected channel to decide m_last.
    adc_next_chan u_tail (
        .mask       (scan_mask),
        .idx        (scan_ch),
        .from_start (1'b0),
        .nxt        (tail_ch),
        .none       (tail_none)
    );

    assign unused_scan = ^{tail_ch, scan_none};

    always_comb begin
        state_d     = state;
        snap_data_d = snap_data;
        snap_mask_d = snap_mask;
        out_d       = out_q;
        valid_d     = valid_q;
        busy_d      = busy;
        drop_d      = drop_count;

        case (state)
            IDLE: ;
            SEND: begin
                if (advance) begin
                    out_d.chan = scan_ch;
                    out_d.data = snap_data[slice_lo(scan_ch) +: SAMPLE_W];
                    out_d.last = tail_none;
                end else if (hs && !capture) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
                if (drop && (drop_count != '1)) begin
                    drop_d = drop_count + DROP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A capture from IDLE or on the final handshake starts a new drain.
        if (capture) begin
            state_d     = SEND;
            snap_data_d = frame_data;
            snap_mask_d = ch_mask;
            out_d.chan  = scan_ch;
            out_d.data  = frame_data[slice_lo(scan_ch) +: SAMPLE_W];
            out_d.last  = tail_none;
            valid_d     = 1'b1;
            busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            snap_data  <= '0;
            snap_mask  <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            busy       <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_d;
            snap_data  <= snap_data_d;
            snap_mask  <= snap_mask_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            busy       <= busy_d;
            drop_count <= drop_d;
        end
    end

    assign stream.m_valid = valid_q;
    assign stream.m_data  = out_q.data;
    assign stream.m_chan  = out_q.chan;
    assign stream.m_last  = out_q.last;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Randomized bench for adc_frame_reader against a queue-based sample model;
// a second instance with a 2-bit drop counter exercises saturation.
module tb_adc_frame_reader;
    import adc_pkg::*;

    typedef struct packed {
        logic [CH_W-1:0]     chan;
        logic [SAMPLE_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               frame_valid = 1'b0;
    logic [FRAME_W-1:0] frame_data = '0;
    logic [NUM_CH-1:0]  ch_mask = '0;
    logic               busy, busy2;
    logic [7:0]         drop_count;
    logic [1:0]         drop_count2;

    adc_frame_reader_if bus ();
    adc_frame_reader_if bus2 ();
    assign bus2.m_ready = bus.m_ready;

    adc_frame_reader #(.DROP_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid),
        .frame_data(frame_data), .ch_mask(ch_mask), .stream(bus),
        .busy(busy), .drop_count(drop_count)
    );

    adc_frame_reader #(.DROP_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .frame_valid(frame_valid),
        .frame_data(frame_data), .ch_mask(ch_mask), .stream(bus2),
        .busy(busy2), .drop_count(drop_count2)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   drops  = 0;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    // Model: pending samples of the frame being drained, head = presented sample.
    function automatic void model_edge(input logic fv, input logic [NUM_CH-1:0] mask,
                                       input logic [FRAME_W-1:0] data, input logic rdy);
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (fv) begin
            if (q.size() != 0) drops++;
            else
                for (int k = 0; k < NUM_CH; k++)
                    if (mask[k]) q.push_back('{chan: CH_W'(k), data: data[k*SAMPLE_W +: SAMPLE_W]});
        end
    endfunction

    function automatic logic [26:0] exp_word();
        logic v;
        exp_t h;
        int   d8, d2;
        v = (q.size() != 0);
        h = '0;
        if (v) h = q[0];
        d8 = (drops > 255) ? 255 : drops;
        d2 = (drops > 3) ? 3 : drops;
        return {v, v, v, h.chan, h.data, v && (q.size() == 1), 8'(d8), 2'(d2)};
    endfunction

    function automatic logic [26:0] obs_word();
        logic v;
        v = bus.m_valid;
        return {v, busy, busy2, v ? bus.m_chan : CH_W'(0), v ? bus.m_data : SAMPLE_W'(0),
                v & bus.m_last, drop_count, drop_count2};
    endfunction

    function automatic logic [FRAME_W-1:0] ramp_frame(input int base);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_CH; k++) f[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(base + k);
        return f;
    endfunction

    function automatic logic [FRAME_W-1:0] rand_frame();
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int k = 0; k < NUM_CH; k++) f[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
        return f;
    endfunction

    function automatic logic [NUM_CH-1:0] rand_mask();
        return NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
    endfunction

    task automatic step(input logic fv, input logic [NUM_CH-1:0] mask,
                        input logic [FRAME_W-1:0] data, input logic rdy);
        frame_valid = fv;
        ch_mask     = mask;
        frame_data  = data;
        bus.m_ready = rdy;
        @(posedge clk);
        model_edge(fv, mask, data, rdy);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        frame_valid = 1'b0;
        bus.m_ready = 1'b0;
        @(posedge clk);
        q.delete();
        drops = 0;
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_chan, bus.m_last, busy, busy2, drop_count, drop_count2} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h c=%0d l=%b busy=%b drop=%0d want all zero",
                     bus.m_valid, bus.m_data, bus.m_chan, bus.m_last, busy, drop_count);
        end else passes++;
        step(1'b0, NUM_CH'($urandom), rand_frame(), 1'b1);
        checks++;
        if (obs_word() !== exp_word()) begin
            fails++; $display("FAIL reset_idle: got %h want %h", obs_word(), exp_word());
        end else passes++;
    endtask

    task automatic test_full_frame();
        for (int i = 0; i < 11; i++) begin
            if (i == 0) step(1'b1, 8'hFF, ramp_frame(10'h100), 1'b1);
            else        step(1'b0, NUM_CH'($urandom), rand_frame(), 1'b1);
            checks++;
            if (obs_word() !== exp_word()) begin
                fails++; $display("FAIL full_frame cyc %0d: got %h want %h", i, obs_word(), exp_word());
            end else passes++;
        end
    endtask

    task automatic test_sparse_mask();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) step(1'b1, 8'b1010_0100, rand_frame(), 1'b1);
            else        step(1'b0, NUM_CH'($urandom), rand_frame(), 1'b1);
            checks++;
            if (obs_word() !== exp_word()) begin
                fails++; $display("FAIL sparse_mask cyc %0d: got %h want %h", i, obs_word(), exp_word());
            end else passes++;
        end
    endtask

    task automatic test_backpressure();
        step(1'b1, rand_mask() | 8'h01, rand_frame(), 1'b0);
        for (int i = 0; i < 15; i++) begin
            if (i < 5) step(1'b0, NUM_CH'($urandom), rand_frame(), 1'b0);
            else       step(1'b0, NUM_CH'($urandom), rand_frame(), 1'b1);
            checks++;
            if (obs_word() !== exp_word()) begin
                fails++; $display("FAIL backpressure cyc %0d: got %h want %h", i, obs_word(), exp_word());
            end else passes++;
        end
    endtask

    task automatic test_drops();
        step(1'b1, 8'hFF, ramp_frame(10'h200), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, rand_mask(), rand_frame(), 1'b0);
        checks++;
        if (drop_count !== 8'd3) begin
            fails++; $display("FAIL drop_three: got %0d want 3", drop_count);
        end else passes++;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, rand_frame(), 1'b1);
            checks++;
            if (obs_word() !== exp_word()) begin
                fails++; $display("FAIL drop_drain cyc %0d: got %h want %h", i, obs_word(), exp_word());
            end else passes++;
        end
        step(1'b1, 8'hFF, ramp_frame(10'h300), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, rand_mask(), rand_frame(), 1'b0);
        checks++;
        if ({drop_count, drop_count2} !== {8'd8, 2'd3}) begin
            fails++; $display("FAIL drop_saturate: got %0d/%0d want 8/3", drop_count, drop_count2);
        end else passes++;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, rand_frame(), 1'b1);
            checks++;
            if (obs_word() !== exp_word()) begin
                fails++; $display("FAIL sat_drain cyc %0d: got %h want %h", i, obs_word(), exp_word());
            end else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [NUM_CH-1:0] mb;
        int lo;
        step(1'b1, rand_mask(), rand_frame(), 1'b1);
        for (int i = 0; i < NUM_CH && q.size() > 1; i++) step(1'b0, '0, rand_frame(), 1'b1);
        mb = rand_mask();
        lo = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) if (mb[k]) lo = k;
        step(1'b1, mb, rand_frame(), 1'b1);
        checks++;
        if (obs_word() !== exp_word() || busy !== 1'b1 || bus.m_chan !== CH_W'(lo)) begin
            fails++; $display("FAIL back_to_back: got %h chan %0d want %h chan %0d",
                              obs_word(), bus.m_chan, exp_word(), lo);
        end else passes++;
        for (int i = 0; i < NUM_CH && q.size() > 1; i++) step(1'b0, '0, rand_frame(), 1'b1);
        step(1'b1, '0, rand_frame(), 1'b1);
        checks++;
        if (obs_word() !== exp_word() || busy !== 1'b0) begin
            fails++; $display("FAIL last_zero_mask: got %h want %h", obs_word(), exp_word());
        end else passes++;
        step(1'b1, '0, rand_frame(), 1'b1);
        checks++;
        if (obs_word() !== exp_word()) begin
            fails++; $display("FAIL idle_zero_mask: got %h want %h", obs_word(), exp_word());
        end else passes++;
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hFF, rand_frame(), 1'b1);
        step(1'b0, '0, rand_frame(), 1'b1);
        step(1'b0, '0, rand_frame(), 1'b1);
        do_reset();
        checks++;
        if ({bus.m_valid, bus.m_data, bus.m_chan, bus.m_last, busy, busy2, drop_count, drop_count2} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got v=%b d=%h c=%0d l=%b busy=%b drop=%0d want all zero",
                     bus.m_valid, bus.m_data, bus.m_chan, bus.m_last, busy, drop_count);
        end else passes++;
        for (int i = 0; i < 14; i++) begin
            if (i == 3) step(1'b1, rand_mask(), rand_frame(), 1'b1);
            else        step(1'b0, NUM_CH'($urandom), rand_frame(), 1'b1);
            checks++;
            if (obs_word() !== exp_word()) begin
                fails++; $display("FAIL after_reset cyc %0d: got %h want %h", i, obs_word(), exp_word());
            end else passes++;
        end
    endtask

    task automatic test_random();
        logic fv, rdy;
        logic [NUM_CH-1:0] m;
        for (int i = 0; i < 400; i++) begin
            fv  = ($urandom_range(0, 3) == 0);
            m   = ($urandom_range(0, 7) == 0) ? '0 : NUM_CH'($urandom);
            rdy = ($urandom_range(0, 9) < 7);
            step(fv, m, rand_frame(), rdy);
            checks++;
            if (obs_word() !== exp_word()) begin
                fails++; $display("FAIL random cyc %0d: got %h want %h", i, obs_word(), exp_word());
            end else passes++;
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_sparse_mask();
        test_backpressure();
        test_drops();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
